// File: rtl/proc_control_fsm_if.sv
// Handshake and control bundle between the sequencer and the datapath it steers.
// The master side is the sequencer; the slave side is the datapath and instruction source.
interface proc_control_fsm_if #(
  parameter int unsigned NUM_REGS = 8
);
  logic                Run;
  logic [8:0]          IR;
  logic                IRin;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic                DINout;
  logic                Ain;
  logic                Gin;
  logic                Gout;
  logic [1:0]          AluOp;
  logic                Done;
  logic                Busy;

  modport master (
    input  Run, IR,
    output IRin, Rin, Rout, DINout, Ain, Gin, Gout, AluOp, Done, Busy
  );

  modport slave (
    output Run, IR,
    input  IRin, Rin, Rout, DINout, Ain, Gin, Gout, AluOp, Done, Busy
  );
endinterface

// File: rtl/proc_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit bus processor: steps each
// instruction through T0..T3 and decodes IR into datapath enables.
module proc_control_fsm #(
  parameter int unsigned NUM_REGS = 8
) (
  input  logic                   Clock,
  input  logic                   Resetn,
  proc_control_fsm_if.master     bus
);

  typedef enum logic [1:0] {T0, T1, T2, T3} tstep_t;

  typedef enum logic [2:0] {
    OP_MV   = 3'b000,
    OP_MVI  = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_AND  = 3'b100,
    OP_SLT  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_t;

  tstep_t     tstep;
  op_t        op;
  logic [2:0] fx;
  logic [2:0] fy;
  logic       is_alu;

  // Indices at or beyond NUM_REGS select nothing.
  function automatic logic [NUM_REGS-1:0] reg_sel(input logic [2:0] idx);
    logic [NUM_REGS-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if ({29'd0, idx} == i) res[i] = 1'b1;
    end
    return res;
  endfunction

  always_comb begin
    op     = op_t'(bus.IR[8:6]);
    fx     = bus.IR[5:3];
    fy     = bus.IR[2:0];
    is_alu = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_SLT);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tstep <= T0;
    end else begin
      case (tstep)
        T0:      tstep <= bus.Run ? T1 : T0;
        T1:      tstep <= is_alu ? T2 : T0;
        T2:      tstep <= T3;
        default: tstep <= T0;
      endcase
    end
  end

  // Outputs are decoded combinationally and gated by Resetn so they fall
  // asynchronously with reset, including the Run-driven IRin in T0.
  always_comb begin
    bus.IRin   = 1'b0;
    bus.Rin    = '0;
    bus.Rout   = '0;
    bus.DINout = 1'b0;
    bus.Ain    = 1'b0;
    bus.Gin    = 1'b0;
    bus.Gout   = 1'b0;
    bus.AluOp  = 2'b00;
    bus.Done   = 1'b0;
    bus.Busy   = 1'b0;
    if (Resetn) begin
      bus.Busy = (tstep != T0);
      case (tstep)
        T0: bus.IRin = bus.Run;
        T1: begin
          case (op)
            OP_MV: begin
              bus.Rout = reg_sel(fy);
              bus.Rin  = reg_sel(fx);
              bus.Done = 1'b1;
            end
            OP_MVI: begin
              bus.DINout = 1'b1;
              bus.Rin    = reg_sel(fx);
              bus.Done   = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_SLT: begin
              bus.Rout = reg_sel(fx);
              bus.Ain  = 1'b1;
            end
            default: bus.Done = 1'b1;
          endcase
        end
        T2: begin
          bus.Rout = reg_sel(fy);
          bus.Gin  = 1'b1;
          case (op)
            OP_SUB:  bus.AluOp = 2'b01;
            OP_AND:  bus.AluOp = 2'b10;
            OP_SLT:  bus.AluOp = 2'b11;
            default: bus.AluOp = 2'b00;
          endcase
        end
        default: begin
          bus.Gout = 1'b1;
          bus.Rin  = reg_sel(fx);
          bus.Done = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: NUM_REGS=8 and NUM_REGS=4 instances run in lockstep
// against per-cycle expected output vectors queued when each instruction starts.
module tb_proc_control_fsm;

  logic Clock;
  logic Resetn;

  proc_control_fsm_if #(.NUM_REGS(8)) bus8 ();
  proc_control_fsm_if #(.NUM_REGS(4)) bus4 ();

  proc_control_fsm #(.NUM_REGS(8)) dut8 (.Clock(Clock), .Resetn(Resetn), .bus(bus8.master));
  proc_control_fsm #(.NUM_REGS(4)) dut4 (.Clock(Clock), .Resetn(Resetn), .bus(bus4.master));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  logic [24:0] q8[$];
  logic [24:0] q4[$];
  logic [24:0] obs8;
  logic [24:0] obs4;
  logic        last_done;
  logic        last_irin;

  // Vector layout: {IRin, Rin[7:0], Rout[7:0], DINout, Ain, Gin, Gout, AluOp[1:0], Done, Busy}
  assign obs8 = {bus8.IRin, bus8.Rin, bus8.Rout, bus8.DINout, bus8.Ain, bus8.Gin,
                 bus8.Gout, bus8.AluOp, bus8.Done, bus8.Busy};
  assign obs4 = {bus4.IRin, 4'b0000, bus4.Rin, 4'b0000, bus4.Rout, bus4.DINout, bus4.Ain,
                 bus4.Gin, bus4.Gout, bus4.AluOp, bus4.Done, bus4.Busy};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] vec(input logic irin, input logic [7:0] rin,
      input logic [7:0] rout, input logic din, input logic ain, input logic gin,
      input logic gout, input logic [1:0] alu, input logic done, input logic busy);
    return {irin, rin, rout, din, ain, gin, gout, alu, done, busy};
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] idx, input int unsigned n);
    logic [7:0] r;
    r = 8'h00;
    if (idx < n) r[idx] = 1'b1;
    return r;
  endfunction

  task automatic push(input bit sel4, input logic [24:0] v);
    if (sel4) q4.push_back(v);
    else      q8.push_back(v);
  endtask

  // Queue the T0 cycle and, if Run starts a fetch, every cycle of that instruction.
  task automatic push_exp(input bit sel4, input logic run, input logic [8:0] ir);
    int unsigned n;
    logic [7:0]  rx, ry;
    n  = sel4 ? 4 : 8;
    rx = oh(ir[5:3], n);
    ry = oh(ir[2:0], n);
    push(sel4, vec(run, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0));
    if (run) begin
      case (ir[8:6])
        3'b000: push(sel4, vec(0, rx, ry, 0, 0, 0, 0, 2'b00, 1, 1));
        3'b001: push(sel4, vec(0, rx, 8'h00, 1, 0, 0, 0, 2'b00, 1, 1));
        3'b010, 3'b011, 3'b100, 3'b101: begin
          push(sel4, vec(0, 8'h00, rx, 0, 1, 0, 0, 2'b00, 0, 1));
          push(sel4, vec(0, 8'h00, ry, 0, 0, 1, 0, 2'(ir[8:6] - 3'd2), 0, 1));
          push(sel4, vec(0, rx, 8'h00, 0, 0, 0, 1, 2'b00, 1, 1));
        end
        default: push(sel4, vec(0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1));
      endcase
    end
  endtask

  task automatic step(input logic run, input logic [8:0] ir);
    logic [24:0] e8, e4;
    @(negedge Clock);
    Resetn   = 1'b1;
    bus8.Run = run;  bus8.IR = ir;
    bus4.Run = run;  bus4.IR = ir;
    if (q8.size() == 0) push_exp(1'b0, run, ir);
    if (q4.size() == 0) push_exp(1'b1, run, ir);
    #2;
    e8 = q8.pop_front();
    e4 = q4.pop_front();
    chk("out8", {7'd0, obs8}, {7'd0, e8});
    chk("out4", {7'd0, obs4}, {7'd0, e4});
    chk("bus1", {31'd0, ($countones(bus8.Rout) + bus8.DINout + bus8.Gout) <= 1}, 32'd1);
    last_done = bus8.Done;
    last_irin = bus8.IRin;
  endtask

  task automatic run_instr(input logic [8:0] ir);
    step(1'b1, ir);
    for (int k = 0; k < 4 && q8.size() != 0; k++) step(1'b0, ir);
    if (q8.size() != 0) begin
      chk("instr_timeout", q8.size(), 0);
      q8.delete();
      q4.delete();
    end
  endtask

  initial begin
    logic [7:0] done_mask, irin_mask;
    Resetn   = 1'b0;
    bus8.Run = 1'b1;  bus8.IR = 9'b001_010_000;
    bus4.Run = 1'b1;  bus4.IR = 9'b001_010_000;

    for (int c = 0; c < 3; c++) begin
      @(negedge Clock);
      #2;
      chk("rst8", {7'd0, obs8}, 32'd0);
      chk("rst4", {7'd0, obs4}, 32'd0);
    end

    // Release with Run high: IRin in T0, then mvi R2.
    run_instr(9'b001_010_000);
    run_instr(9'b010_001_011);   // add R1,R3
    run_instr(9'b101_001_011);   // slt
    run_instr(9'b011_001_011);   // sub

    // Back-to-back with Run held high: mv R0,R5 then sub R4,R4.
    done_mask = '0;
    irin_mask = '0;
    step(1'b1, 9'b000_000_101); irin_mask[1] = last_irin; done_mask[1] = last_done;
    step(1'b1, 9'b000_000_101); irin_mask[2] = last_irin; done_mask[2] = last_done;
    for (int c = 3; c <= 6; c++) begin
      step(1'b1, 9'b011_100_100);
      irin_mask[c] = last_irin;
      done_mask[c] = last_done;
    end
    step(1'b0, 9'b011_100_100); irin_mask[7] = last_irin; done_mask[7] = last_done;
    chk("b2b_done", {24'd0, done_mask}, 32'h44);
    chk("b2b_irin", {24'd0, irin_mask}, 32'h0a);

    run_instr(9'b111_011_010);   // reserved -> nop
    run_instr(9'b110_000_000);   // reserved -> nop
    run_instr(9'b000_110_001);   // mv R6,R1: Rin empty on the 4-reg instance
    run_instr(9'b000_011_011);   // mv R3,R3 self-reload
    run_instr(9'b010_111_101);   // add R7,R5: both fields out of range on 4 regs

    // Reset during T2 of and R2,R1.
    step(1'b1, 9'b100_010_001);
    step(1'b0, 9'b100_010_001);
    step(1'b0, 9'b100_010_001);
    #1 Resetn = 1'b0;
    #1;
    chk("midrst8", {7'd0, obs8}, 32'd0);
    chk("midrst4", {7'd0, obs4}, 32'd0);
    q8.delete();
    q4.delete();
    @(posedge Clock);
    #1;
    chk("midrst_nodone", {31'd0, bus8.Done | bus4.Done}, 32'd0);
    step(1'b0, 9'b100_010_001);
    run_instr(9'b000_001_010);   // clean mv R1,R2

    for (int r = 0; r < 12; r++) begin
      run_instr(9'($urandom_range(511, 0)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
